// File: rtl/sif_mc_arbiter.sv
// N-channel SIF arbiter: per-channel request FIFOs, round-robin serialisation onto
// one WA port, read-data routing back to the originating channel, illegal-strobe counting.
module sif_mc_arbiter #(
  parameter int NCH   = 4,
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    xa_wr_st,
  input  logic [NCH-1:0]    xa_rd_st,
  input  logic [NCH*AW-1:0] xa_addr,
  input  logic [NCH*DW-1:0] xa_wdata,
  output logic [NCH-1:0]    xa_ready,
  output logic [NCH-1:0]    xa_illegal,
  output logic [NCH-1:0]    xa_rvalid,
  output logic [DW-1:0]     xa_rdata,
  output logic [NCH*CW-1:0] illegal_cnt,
  output logic              wa_wr_st,
  output logic              wa_rd_st,
  output logic [AW-1:0]     wa_addr,
  output logic [DW-1:0]     wa_wdata,
  input  logic              wa_ack,
  input  logic              wa_rvalid,
  input  logic [DW-1:0]     wa_rdata
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW = $clog2(DEPTH);
  localparam int KW = IW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t          state, state_d;
  logic [1:0]      rst_sync;
  logic            rst_i;
  logic [PW-1:0]   rr_ptr, grant, gnt_idx, cand;
  logic            found, load, ack_take, rd_take;
  logic [NCH-1:0]  push, pop, nonempty;

  logic            mem_rd   [NCH][DEPTH];
  logic [AW-1:0]   mem_addr [NCH][DEPTH];
  logic [DW-1:0]   mem_data [NCH][DEPTH];
  logic [IW-1:0]   wr_ptr [NCH];
  logic [IW-1:0]   rd_ptr [NCH];
  logic [KW-1:0]   cnt    [NCH];
  logic [KW-1:0]   cnt_nx [NCH];

  // Reset asserts immediately but releases two clocks after rst falls.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    push     = '0;
    nonempty = '0;
    for (int i = 0; i < NCH; i++) begin
      push[i]     = (xa_wr_st[i] ^ xa_rd_st[i]) & xa_ready[i];
      nonempty[i] = (cnt[i] != '0);
      cnt_nx[i]   = cnt[i] + KW'(push[i]) - KW'(pop[i]);
    end
  end

  // First non-empty channel at or after rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NCH);
      if (!found && nonempty[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    ack_take = 1'b0;
    rd_take  = 1'b0;
    pop      = '0;
    case (state)
      IDLE: if (found) begin
        load    = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (wa_ack) begin
        ack_take   = 1'b1;
        pop[grant] = 1'b1;
        state_d    = wa_rd_st ? WAIT_RD : IDLE;
      end
      WAIT_RD: if (wa_rvalid) begin
        rd_take = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: FIFO storage is not reset; the occupancy counters alone define which entries are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) begin
        mem_rd[i][wr_ptr[i]]   <= xa_rd_st[i];
        mem_addr[i][wr_ptr[i]] <= xa_addr[i*AW +: AW];
        mem_data[i][wr_ptr[i]] <= xa_wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      xa_ready    <= '1;
      xa_illegal  <= '0;
      illegal_cnt <= '0;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i]        <= cnt_nx[i];
        xa_ready[i]   <= (cnt_nx[i] != KW'(DEPTH));
        xa_illegal[i] <= xa_wr_st[i] & xa_rd_st[i];
        if (xa_wr_st[i] && xa_rd_st[i] && (illegal_cnt[i*CW +: CW] != {CW{1'b1}}))
          illegal_cnt[i*CW +: CW] <= illegal_cnt[i*CW +: CW] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wa_wr_st  <= 1'b0;
      wa_rd_st  <= 1'b0;
      wa_addr   <= '0;
      wa_wdata  <= '0;
      grant     <= '0;
      rr_ptr    <= '0;
      xa_rvalid <= '0;
      xa_rdata  <= '0;
    end else begin
      xa_rvalid <= '0;
      if (load) begin
        grant    <= gnt_idx;
        wa_addr  <= mem_addr[gnt_idx][rd_ptr[gnt_idx]];
        wa_wdata <= mem_data[gnt_idx][rd_ptr[gnt_idx]];
        wa_wr_st <= ~mem_rd[gnt_idx][rd_ptr[gnt_idx]];
        wa_rd_st <= mem_rd[gnt_idx][rd_ptr[gnt_idx]];
      end
      if (ack_take) begin
        wa_wr_st <= 1'b0;
        wa_rd_st <= 1'b0;
        rr_ptr   <= (grant == PW'(NCH - 1)) ? '0 : grant + 1'b1;
      end
      if (rd_take) begin
        xa_rdata         <= wa_rdata;
        xa_rvalid[grant] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sif_mc_arbiter.sv
// Scoreboard bench for sif_mc_arbiter: the driver queues expected WA transactions and
// read returns, an independent monitor pops and compares whenever the DUT presents them.
module tb_sif_mc_arbiter;

  localparam int NCH = 4, AW = 8, DW = 16, DEPTH = 4, CW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH-1:0]    xa_wr_st = '0, xa_rd_st = '0;
  logic [NCH*AW-1:0] xa_addr = '0;
  logic [NCH*DW-1:0] xa_wdata = '0;
  logic [NCH-1:0]    xa_ready, xa_illegal, xa_rvalid;
  logic [DW-1:0]     xa_rdata;
  logic [NCH*CW-1:0] illegal_cnt;
  logic              wa_wr_st, wa_rd_st;
  logic [AW-1:0]     wa_addr;
  logic [DW-1:0]     wa_wdata;
  logic              wa_ack = 1'b1, wa_rvalid = 1'b0;
  logic [DW-1:0]     wa_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int ill_seen [NCH] = '{default: 0};
  logic [AW+DW+1:0] exp_wa [$];
  logic [NCH+DW-1:0] exp_rd [$];

  sif_mc_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .xa_wr_st(xa_wr_st), .xa_rd_st(xa_rd_st), .xa_addr(xa_addr), .xa_wdata(xa_wdata),
    .xa_ready(xa_ready), .xa_illegal(xa_illegal), .xa_rvalid(xa_rvalid), .xa_rdata(xa_rdata),
    .illegal_cnt(illegal_cnt),
    .wa_wr_st(wa_wr_st), .wa_rd_st(wa_rd_st), .wa_addr(wa_addr), .wa_wdata(wa_wdata),
    .wa_ack(wa_ack), .wa_rvalid(wa_rvalid), .wa_rdata(wa_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wa(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_wa.push_back({~rd, rd, a, d});
  endtask

  task automatic issue(input logic [NCH-1:0] wr, input logic [NCH-1:0] rd,
                       input logic [NCH*AW-1:0] a, input logic [NCH*DW-1:0] d);
    xa_wr_st = wr;
    xa_rd_st = rd;
    xa_addr  = a;
    xa_wdata = d;
    tick();
    xa_wr_st = '0;
    xa_rd_st = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_wa.size() != 0 || exp_rd.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(exp_wa.size() + exp_rd.size()), 64'd0);
    repeat (4) tick();
  endtask

  // Monitor: compares every accepted WA strobe and every read return against the queues.
  initial begin
    logic [AW+DW+1:0] e;
    logic [NCH+DW-1:0] r;
    forever begin
      @(negedge clk);
      if (!rst && (wa_wr_st || wa_rd_st) && wa_ack) begin
        if (exp_wa.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wa_unexpected: got wr=%b rd=%b addr=%h data=%h expected no transaction",
                   wa_wr_st, wa_rd_st, wa_addr, wa_wdata);
        end else begin
          e = exp_wa.pop_front();
          check("wa_txn", 64'({wa_wr_st, wa_rd_st, wa_addr, wa_wdata}), 64'(e));
        end
      end
      if (|xa_rvalid) begin
        if (exp_rd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_unexpected: got rvalid=%b rdata=%h expected no return", xa_rvalid, xa_rdata);
        end else begin
          r = exp_rd.pop_front();
          check("rd_return", 64'({xa_rvalid, xa_rdata}), 64'(r));
        end
      end
      for (int i = 0; i < NCH; i++) ill_seen[i] += int'(xa_illegal[i]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap [NCH];

    // Power-on reset
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wa", 64'({wa_wr_st, wa_rd_st, wa_addr, wa_wdata}), 64'd0);
    check("rst_xa", 64'({xa_ready, xa_illegal, xa_rvalid, xa_rdata}), 64'({4'hF, 4'h0, 4'h0, 16'h0}));
    check("rst_illcnt", 64'(illegal_cnt), 64'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Round robin from rr_ptr=0
    for (int i = 0; i < NCH; i++) push_wa(1'b0, 8'(8'h20 + i), 16'(16'hA000 + i));
    issue(4'hF, 4'h0, 32'h23222120, 64'hA003_A002_A001_A000);
    drain("rr0_drain");

    // ch1 alone moves rr_ptr to 2, then all four -> 2,3,0,1
    push_wa(1'b0, 8'h31, 16'hB001);
    issue(4'b0010, 4'h0, 32'h0000_3100, 64'h0000_0000_B001_0000);
    drain("ch1_drain");
    for (int i = 0; i < NCH; i++) push_wa(1'b0, 8'(8'h60 + ((i + 2) % 4)), 16'(16'hC000 + ((i + 2) % 4)));
    issue(4'hF, 4'h0, 32'h63626160, 64'hC003_C002_C001_C000);
    drain("rr2_drain");

    // Single write on ch2; rr_ptr then 3 so the next burst runs 3,0,1,2
    push_wa(1'b0, 8'h3C, 16'hBEEF);
    issue(4'b0100, 4'h0, 32'h003C_0000, 64'h0000_BEEF_0000_0000);
    drain("ch2_drain");
    check("ch2_strobe_low", 64'({wa_wr_st, wa_rd_st}), 64'd0);
    for (int i = 0; i < NCH; i++) push_wa(1'b0, 8'(8'h70 + ((i + 3) % 4)), 16'(16'hD000 + ((i + 3) % 4)));
    issue(4'hF, 4'h0, 32'h73727170, 64'hD003_D002_D001_D000);
    drain("rr3_drain");

    // Read routing: ch1 read, ch0 write queued while the read is outstanding
    push_wa(1'b1, 8'h10, 16'h0000);
    issue(4'h0, 4'b0010, 32'h0000_1000, 64'h0);
    n = 0;
    while (!wa_rd_st && n < 20) begin tick(); n++; end
    check("rd_strobe_seen", 64'(wa_rd_st), 64'd1);
    push_wa(1'b0, 8'h55, 16'h5555);
    issue(4'b0001, 4'h0, 32'h0000_0055, 64'h0000_0000_0000_5555);
    check("rd_wait_idle1", 64'({wa_wr_st, wa_rd_st}), 64'd0);
    tick();
    check("rd_wait_idle2", 64'({wa_wr_st, wa_rd_st}), 64'd0);
    tick();
    check("rd_wait_idle3", 64'({wa_wr_st, wa_rd_st}), 64'd0);
    wa_rvalid = 1'b1;
    wa_rdata  = 16'h1234;
    exp_rd.push_back({4'b0010, 16'h1234});
    tick();
    wa_rvalid = 1'b0;
    wa_rdata  = 16'h0;
    check("rd_rvalid_pulse", 64'({xa_rvalid, xa_rdata}), 64'({4'b0010, 16'h1234}));
    tick();
    check("rd_rvalid_drop", 64'(xa_rvalid), 64'd0);
    drain("rd_drain");

    // Backpressure: ack held low, five pushes on ch0, only four accepted
    wa_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_ready", 64'(xa_ready[0]), 64'(k < 4));
      if (k < 4) push_wa(1'b0, 8'(8'h40 + k), 16'(16'hE000 + k));
      issue(4'b0001, 4'h0, 32'(8'(8'h40 + k)), 64'(16'(16'hE000 + k)));
    end
    repeat (3) tick();
    check("bp_hold", 64'({wa_wr_st, wa_rd_st, wa_addr, wa_wdata}), 64'({2'b10, 8'h40, 16'hE000}));
    check("bp_full", 64'(xa_ready), 64'(4'b1110));
    wa_ack = 1'b1;
    drain("bp_drain");
    check("bp_ready_back", 64'(xa_ready), 64'hF);

    // Async reset during ISSUE with three writes queued
    wa_ack = 1'b0;
    for (int k = 0; k < 3; k++)
      issue(4'b0001, 4'h0, 32'(8'(8'h50 + k)), 64'(16'(16'hF000 + k)));
    tick();
    check("rst_pre_strobe", 64'(wa_wr_st), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_strobe", 64'({wa_wr_st, wa_rd_st}), 64'd0);
    tick();
    rst = 1'b0;
    wa_ack = 1'b1;
    repeat (3) tick();
    check("rst_post_ready", 64'(xa_ready), 64'hF);
    check("rst_post_illcnt", 64'(illegal_cnt), 64'd0);
    check("rst_post_rvalid", 64'(xa_rvalid), 64'd0);
    repeat (10) tick();
    check("rst_lost_queue", 64'({wa_wr_st, wa_rd_st}), 64'd0);

    // Illegal strobes on ch3 for 300 cycles, ch0 write in the middle
    for (int i = 0; i < NCH; i++) snap[i] = ill_seen[i];
    xa_wr_st[3] = 1'b1;
    xa_rd_st[3] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        xa_wr_st[0]    = 1'b1;
        xa_addr[7:0]   = 8'h66;
        xa_wdata[15:0] = 16'h6666;
        push_wa(1'b0, 8'h66, 16'h6666);
      end
      tick();
      xa_wr_st[0] = 1'b0;
    end
    xa_wr_st = '0;
    xa_rd_st = '0;
    repeat (2) tick();
    for (int i = 0; i < NCH; i++)
      check($sformatf("ill_pulses_ch%0d", i), 64'(ill_seen[i] - snap[i]), 64'((i == 3) ? 300 : 0));
    check("ill_cnt", 64'(illegal_cnt), 64'h FF00_0000);
    check("ill_ready", 64'(xa_ready), 64'hF);
    drain("ill_drain");

    check("final_queues", 64'(exp_wa.size() + exp_rd.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
